// File: rtl/mult_div_sequencer_if.sv
// mult_div_sequencer_if: request/response bundle between control unit and the MULT/DIV engine
interface mult_div_sequencer_if #(parameter int WIDTH = 32);
  logic start;
  logic op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic busy;
  logic done;
  logic div_zero;
  logic hi_lo_w;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  modport master(output start, op, a_in, b_in, input busy, done, div_zero, hi_lo_w, hi_out, lo_out);
  modport slave(input start, op, a_in, b_in, output busy, done, div_zero, hi_lo_w, hi_out, lo_out);
endinterface

// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer: one-bit-per-cycle signed MULT / restoring DIV feeding HI/LO
module mult_div_sequencer #(parameter int WIDTH = 32) (
  input logic clk,
  input logic reset,
  mult_div_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, ADJUST, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic op_r, sign_a, sign_b, dz;
  logic [WIDTH-1:0] oper, mag_a, mag_b, rem_sub, quo, rem;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic [2*WIDTH-1:0] acc, acc_nx, prod;
  logic [WIDTH:0] shifted, msum;
  logic sub_ok, zero_div;
  assign mag_a = bus.a_in[WIDTH-1] ? -bus.a_in : bus.a_in;
  assign mag_b = bus.b_in[WIDTH-1] ? -bus.b_in : bus.b_in;
  assign zero_div = bus.op && (bus.b_in == '0);
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.div_zero = (state == DONE) && dz;
  assign bus.hi_lo_w = (state == DONE) && !dz;
  assign bus.hi_out = hi_r;
  assign bus.lo_out = lo_r;
  // acc holds {partial product high, multiplier} for MULT and {remainder, quotient} for DIV
  always_comb begin
    msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, oper} : '0);
    shifted = acc[2*WIDTH-1:WIDTH-1];
    sub_ok = shifted >= {1'b0, oper};
    rem_sub = shifted[WIDTH-1:0] - oper;
    acc_nx = op_r ? {sub_ok ? rem_sub : shifted[WIDTH-1:0], acc[WIDTH-2:0], sub_ok}
                  : {msum, acc[WIDTH-1:1]};
    prod = (sign_a ^ sign_b) ? -acc : acc;
    quo = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  // next-state: zero divisor skips straight to DONE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = bus.start ? (zero_div ? DONE : CALC) : IDLE;
      CALC: state_nx = (cnt == CW'(WIDTH - 1)) ? ADJUST : CALC;
      ADJUST: state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  // datapath: latch magnitudes on start, iterate in CALC, sign-fix into HI/LO on ADJUST
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      op_r <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      dz <= 1'b0;
      oper <= '0;
      acc <= '0;
      hi_r <= '0;
      lo_r <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        op_r <= bus.op;
        sign_a <= bus.a_in[WIDTH-1];
        sign_b <= bus.b_in[WIDTH-1];
        dz <= zero_div;
        oper <= bus.op ? mag_b : mag_a;
        acc <= {{WIDTH{1'b0}}, bus.op ? mag_a : mag_b};
        cnt <= '0;
      end
      if (state == CALC) begin
        acc <= acc_nx;
        cnt <= cnt + 1'b1;
      end
      if (state == ADJUST) begin
        hi_r <= op_r ? rem : prod[2*WIDTH-1:WIDTH];
        lo_r <= op_r ? quo : prod[WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_mult_div_sequencer.sv
// tb_mult_div_sequencer: scoreboard bench for the MULT/DIV sequencer
module tb_mult_div_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;
  typedef struct {
    logic dz;
    logic [31:0] hi;
    logic [31:0] lo;
    int due;
  } exp_t;
  exp_t sb[$];
  mult_div_sequencer_if #(.WIDTH(32)) bus();
  mult_div_sequencer #(.WIDTH(32)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // cycle k is the interval after the k-th rising edge
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.due);
        chk("hi_lo_w", bus.hi_lo_w, !e.dz);
        chk("div_zero", bus.div_zero, e.dz);
        chk("hi_out", bus.hi_out, e.hi);
        chk("lo_out", bus.lo_out, e.lo);
      end
    end
  end
  // issue one op starting in the current cycle; returns in the cycle after done
  task automatic run(input logic o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ehi, input logic [31:0] elo, input bit poke);
    exp_t e;
    int lat;
    e.dz = o && (b == 32'h0);
    lat = e.dz ? 1 : 34;
    e.hi = e.dz ? last_hi : ehi;
    e.lo = e.dz ? last_lo : elo;
    e.due = cyc + lat;
    sb.push_back(e);
    bus.start = 1'b1;
    bus.op = o;
    bus.a_in = a;
    bus.b_in = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op = ~o;
    bus.a_in = $urandom;
    bus.b_in = $urandom;
    chk("busy_first", bus.busy, 1);
    repeat (lat - 1) begin @(posedge clk); #1; end
    chk("busy_last", bus.busy, 1);
    if (poke) begin
      bus.start = 1'b1;
      bus.op = 1'b1;
      bus.b_in = 32'h0;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_after", bus.busy, 0);
    chk("done_seen", sb.size(), 0);
    last_hi = e.hi;
    last_lo = e.lo;
  endtask
  initial begin
    bus.start = 1'b0;
    bus.op = 1'b0;
    bus.a_in = '0;
    bus.b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_hi", bus.hi_out, 0);
    chk("rst_lo", bus.lo_out, 0);
    @(posedge clk); #1;
    run(1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run(1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b1);
    run(1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run(1'b1, 32'h00000005, 32'h00000000, 32'h0, 32'h0, 1'b0);
    chk("dz_hold_hi", bus.hi_out, 32'hFFFFFFFF);
    chk("dz_hold_lo", bus.lo_out, 32'hFFFFFFFD);
    run(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run(1'b1, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0);
    run(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0);
    run(1'b0, 32'h12345678, 32'h9, 32'h0, 32'hA3D70A38, 1'b0);
    bus.start = 1'b1;
    bus.op = 1'b0;
    bus.a_in = 32'd3;
    bus.b_in = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    bus.start = 1'b1;
    bus.a_in = 32'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_hi", bus.hi_out, 0);
    chk("abort_lo", bus.lo_out, 0);
    repeat (40) begin @(posedge clk); #1; end
    chk("abort_idle", bus.busy, 0);
    last_hi = '0;
    last_lo = '0;
    run(1'b0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
